// File: rtl/mul_three_arbiter.sv
// Round-robin front end sharing one pipelined mul_three multiplier among NREQ requesters.
// Tracks requester IDs alongside the multiplier pipeline so that each result returns with its owner.
module mul_three_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned MUL_WIDTH = 17,
  parameter int unsigned RES_WIDTH = 32,
  parameter int unsigned MUL_LAT   = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*MUL_WIDTH-1:0] req_a,
  input  logic [NREQ*MUL_WIDTH-1:0] req_b,
  output logic [NREQ-1:0]           gnt,
  output logic [MUL_WIDTH-1:0]      mul_a,
  output logic [MUL_WIDTH-1:0]      mul_b,
  output logic                      mul_start,
  input  logic [RES_WIDTH-1:0]      mul_data,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RES_WIDTH-1:0]      rsp_data,
  output logic                      busy
);

  localparam int unsigned TAGS  = MUL_LAT + 1;
  localparam int unsigned CNT_W = $clog2(MUL_LAT + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      ptr_nx;
  logic [ID_W-1:0]      cand;
  logic [ID_W-1:0]      win;
  logic                 found;
  logic                 issue;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nx;
  logic [TAGS-1:0]      tag_v;
  logic [ID_W-1:0]      tag_id [TAGS];
  logic [MUL_WIDTH-1:0] op_a [NREQ];
  logic [MUL_WIDTH-1:0] op_b [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_a[i] = req_a[i*MUL_WIDTH +: MUL_WIDTH];
    assign op_b[i] = req_b[i*MUL_WIDTH +: MUL_WIDTH];
  end

  // Search begins at the pointer and wraps; first active request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ID_W'((32'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign issue  = found && rst_n;
  assign ptr_nx = (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
  assign cnt_nx = cnt + CNT_W'(issue) - CNT_W'(rsp_valid);

  always_comb begin
    gnt = '0;
    if (issue) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      cnt <= cnt_nx;
      if (issue) begin
        mul_a <= op_a[win];
        mul_b <= op_b[win];
        ptr   <= ptr_nx;
      end else if (mul_start) begin
        mul_a <= '0;
        mul_b <= '0;
      end
      case (state)
        IDLE: begin
          if (issue) begin
            state     <= RUN;
            mul_start <= 1'b1;
          end
        end
        RUN: begin
          if (!issue) begin
            if (cnt_nx != '0) begin
              state <= DRAIN;
            end else begin
              state     <= IDLE;
              mul_start <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (issue) begin
            state <= RUN;
          end else if (cnt_nx == '0) begin
            state     <= IDLE;
            mul_start <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mul_start <= 1'b0;
        end
      endcase
    end
  end

  // Extra leading stage mirrors the operand register, so tags stay aligned with the stalling multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int unsigned i = 0; i < TAGS; i++) tag_id[i] <= '0;
    end else if (issue || mul_start) begin
      tag_v     <= {tag_v[TAGS-2:0], issue};
      tag_id[0] <= issue ? win : '0;
      for (int unsigned i = 1; i < TAGS; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  assign rsp_valid = tag_v[TAGS-1];
  assign rsp_id    = tag_id[TAGS-1];
  // Data is masked outside valid cycles so stale multiplier contents never leak out.
  assign rsp_data  = rsp_valid ? mul_data : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mul_three_arbiter.sv
// Directed bench for mul_three_arbiter with a stalling multiplier model and a response scoreboard.
module tb_mul_three_arbiter;

  localparam int NREQ = 4;
  localparam int MW   = 17;
  localparam int RW   = 32;
  localparam int LAT  = 10;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]  req;
  logic [NREQ*MW-1:0] req_a;
  logic [NREQ*MW-1:0] req_b;
  logic [NREQ-1:0]  gnt;
  logic [MW-1:0]    mul_a;
  logic [MW-1:0]    mul_b;
  logic             mul_start;
  logic [RW-1:0]    mul_data;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [RW-1:0]    rsp_data;
  logic             busy;

  mul_three_arbiter #(
    .NREQ(NREQ), .ID_W(2), .MUL_WIDTH(MW), .RES_WIDTH(RW), .MUL_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_data(mul_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   mptr = 0;
  logic [31:0] mpipe [LAT];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] prod(input logic [16:0] a, input logic [16:0] b);
    logic signed [33:0] p;
    logic signed [33:0] s;
    p = $signed(a) * $signed(b);
    s = p >>> 16;
    return s[31:0];
  endfunction

  // Multiplier model: advances only on edges where start is high.
  initial for (int i = 0; i < LAT; i++) mpipe[i] = '0;
  always @(posedge clk) begin
    if (mul_start) begin
      for (int i = LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
      mpipe[0] <= prod(mul_a, mul_b);
    end
  end
  assign mul_data = mpipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check_grant();
    int         pk;
    logic [3:0] exp;
    pk  = pick(req, mptr);
    exp = '0;
    if (pk >= 0) exp[pk] = 1'b1;
    chk("gnt", 32'(gnt), 32'(exp));
    if (pk >= 0) begin
      q.push_back('{pk, prod(req_a[pk*MW +: MW], req_b[pk*MW +: MW]), cyc + 1 + LAT});
      mptr = (pk + 1) % NREQ;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_grant();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [16:0] a, input logic [16:0] b);
    req_a[i*MW +: MW] = a;
    req_b[i*MW +: MW] = b;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80 && q.size() != 0; i++) step();
    chk("drain_queue_empty", 32'(q.size()), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_mul_start"}, 32'(mul_start), 0);
    chk({tag, "_mul_a"}, 32'(mul_a), 0);
    chk({tag, "_mul_b"}, 32'(mul_b), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Response scoreboard: every rsp_valid must match the oldest outstanding issue on id, data and cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        chk("rsp_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (q.size() != 0 && q[0].due < cyc) begin
        chk("rsp_missing_cycle", 32'(cyc), 32'(q[0].due));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk("idle_mul_start", 32'(mul_start), 0);
    chk("idle_busy", 32'(busy), 0);

    // Single op, positive operands
    set_op(0, 17'h08000, 17'h08000);
    req = 4'b0001;
    step();
    req = '0;
    chk("t1_mul_start", 32'(mul_start), 1);
    chk("t1_mul_a", 32'(mul_a), 32'h08000);
    chk("t1_expected_value", q.size() != 0 ? q[0].data : 32'hx, 32'h00004000);
    wait_drain();
    chk("t1_idle_busy", 32'(busy), 0);

    // Negative operand on requester 2
    set_op(2, 17'h1C000, 17'h08000);
    req = 4'b0100;
    step();
    req = '0;
    chk("t2_expected_value", q.size() != 0 ? q[0].data : 32'hx, 32'hFFFFE000);
    wait_drain();

    // Bring the pointer to wrap via requester 3
    set_op(3, 17'h00123, 17'h1FF00);
    req = 4'b1000;
    step();
    req = '0;
    wait_drain();

    // Fairness: all requesting for 8 cycles
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, 17'($urandom), 17'($urandom));
      step();
    end
    req = '0;
    wait_drain();
    chk("t3_idle_mul_start", 32'(mul_start), 0);

    // Drain then resume in the 5th drain cycle
    set_op(0, 17'h04000, 17'h1E000);
    req = 4'b0001;
    step();
    req = '0;
    step();
    chk("t4_drain_busy", 32'(busy), 1);
    chk("t4_drain_mul_start", 32'(mul_start), 1);
    chk("t4_drain_mul_a", 32'(mul_a), 0);
    repeat (4) step();
    set_op(1, 17'h0A5A5, 17'h00F00);
    req = 4'b0010;
    step();
    req = '0;
    chk("t4_resume_mul_a", 32'(mul_a), 32'h0A5A5);
    wait_drain();
    chk("t4_idle_busy", 32'(busy), 0);
    chk("t4_idle_mul_start", 32'(mul_start), 0);

    // Reset mid-operation
    for (int i = 0; i < NREQ; i++) set_op(i, 17'($urandom), 17'($urandom));
    req = 4'b0111;
    repeat (3) step();
    req = '0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_reset");
    q.delete();
    mptr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) step();
    set_op(3, 17'h07FFF, 17'h07FFF);
    req = 4'b1000;
    step();
    req = '0;
    wait_drain();

    // Ops every third cycle with bubbles between
    for (int n = 0; n < NREQ; n++) begin
      logic [16:0] a;
      logic [16:0] b;
      a = 17'($urandom) | 17'h1;
      b = 17'($urandom) | 17'h1;
      set_op(n, a, b);
      req = 4'(1 << n);
      step();
      req = '0;
      chk("t6_mul_a_issue", 32'(mul_a), 32'(a));
      chk("t6_mul_b_issue", 32'(mul_b), 32'(b));
      step();
      chk("t6_mul_a_bubble", 32'(mul_a), 0);
      chk("t6_mul_b_bubble", 32'(mul_b), 0);
      chk("t6_bubble_start", 32'(mul_start), 1);
      step();
    end
    wait_drain();
    chk("t6_idle_busy", 32'(busy), 0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
